// File: rtl/vx_tensor_pkg.sv
// Shared types and constants for the tensor MMA unit: FSM states, index width
// and a latency helper used by benches.
package vx_tensor_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, STORE} tc_state_t;

    localparam int TC_TILE_N_DFLT = 4;
    localparam int IDX_W          = $clog2(TC_TILE_N_DFLT);

    // start edge -> done-high cycle: 1 + N^2 (load) + N^3 (exec) + N^2 (store)
    function automatic int tc_latency(input int n);
        return 1 + 2 * n * n + n * n * n;
    endfunction

endpackage

// File: rtl/vx_tensor_mac.sv
// Single signed MAC: acc_out = acc_in + sext(a*b), wrapping at ACC_WIDTH bits.
module vx_tensor_mac
    import vx_tensor_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [ACC_WIDTH-1:0]  acc_in,
    output logic [ACC_WIDTH-1:0]  acc_out
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = ACC_WIDTH'(prod);
    assign acc_out  = acc_in + $unsigned(prod_ext);

endmodule

// File: rtl/vx_tensor_mma_unit.sv
// Tile MMA engine: loads N x N tiles A and B, computes C (+)= A*B one MAC per
// cycle, then streams C out row-major over a valid/ready channel.
module vx_tensor_mma_unit
    import vx_tensor_pkg::*;
#(
    parameter int TILE_N     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  acc_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int            IW   = (TILE_N > 1) ? $clog2(TILE_N) : 1;
    localparam logic [IW-1:0] LAST = IW'(TILE_N - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    tc_state_t state;

    logic [TILE_N-1:0][TILE_N-1:0][DATA_WIDTH-1:0] a_q, b_q;
    logic [TILE_N-1:0][TILE_N-1:0][ACC_WIDTH-1:0]  c_q;

    // r/col walk the tile in LOAD and STORE; i/j/k drive the MAC in EXEC
    logic [IW-1:0] r_q, col_q, i_q, j_q, k_q;
    logic          done_q;
    logic [ACC_WIDTH-1:0] mac_out;

    vx_tensor_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .a      (a_q[i_q][k_q]),
        .b      (b_q[k_q][j_q]),
        .acc_in (c_q[i_q][j_q]),
        .acc_out(mac_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            r_q    <= '0;
            col_q  <= '0;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        r_q   <= '0;
                        col_q <= '0;
                        if (!acc_en) c_q <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        a_q[r_q][col_q] <= in_a;
                        b_q[r_q][col_q] <= in_b;
                        col_q <= col_q + ONE;
                        if (col_q == LAST) begin
                            r_q <= r_q + ONE;
                            if (r_q == LAST) state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // counters wrap to zero on exit, ready for the next op
                    c_q[i_q][j_q] <= mac_out;
                    k_q <= k_q + ONE;
                    if (k_q == LAST) begin
                        j_q <= j_q + ONE;
                        if (j_q == LAST) begin
                            i_q <= i_q + ONE;
                            if (i_q == LAST) state <= STORE;
                        end
                    end
                end
                STORE: begin
                    if (out_ready) begin
                        col_q <= col_q + ONE;
                        if (col_q == LAST) begin
                            r_q <= r_q + ONE;
                            if (r_q == LAST) begin
                                state  <= IDLE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == STORE);
    assign out_last  = out_valid && (r_q == LAST) && (col_q == LAST);
    assign out_data  = out_valid ? c_q[r_q][col_q] : '0;
    assign busy      = (state != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_vx_tensor_mma_unit.sv
// Directed bench: N=2/DW16/AW32 and N=4/DW8/AW16 instances checked against a
// plain-arithmetic matrix model plus hand-computed literal result streams.
module tb_vx_tensor_mma_unit;
    import vx_tensor_pkg::*;

    logic        clk = 1'b0, reset = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0, acc_en = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [15:0] in_a = '0, in_b = '0;

    logic        ir0, ov0, ol0, bz0, dn0;
    logic [31:0] od0;
    logic        ir1, ov1, ol1, bz1, dn1;
    logic [15:0] od1;

    always #5 clk = ~clk;

    vx_tensor_mma_unit #(.TILE_N(2), .DATA_WIDTH(16), .ACC_WIDTH(32)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .acc_en(acc_en),
        .in_valid(in_valid), .in_ready(ir0), .in_a(in_a), .in_b(in_b),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_last(ol0), .busy(bz0), .done(dn0));

    vx_tensor_mma_unit #(.TILE_N(4), .DATA_WIDTH(8), .ACC_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .acc_en(acc_en),
        .in_valid(in_valid), .in_ready(ir1), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_last(ol1), .busy(bz1), .done(dn1));

    int sel = 0;
    logic ir, ov, ol, bz, dn;
    longint od;
    always_comb begin
        ir = (sel != 0) ? ir1 : ir0;
        ov = (sel != 0) ? ov1 : ov0;
        ol = (sel != 0) ? ol1 : ol0;
        bz = (sel != 0) ? bz1 : bz0;
        dn = (sel != 0) ? dn1 : dn0;
        od = (sel != 0) ? longint'(od1) : longint'(od0);
    end

    int nvec = 0, nerr = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
    longint mc [2][16];
    longint exp_q[$], cap_q[$];
    bit     expl_q[$];
    bit     prev_stall = 1'b0, prev_ol = 1'b0;
    longint prev_od = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // compare process: every result handshake against the model queue
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (dn) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_with_busy_low", bz, 0);
            end
            if (prev_stall) begin
                chk("stall_valid", ov, 1);
                chk("stall_data", od, prev_od);
                chk("stall_last", ol, prev_ol);
            end
            if (ov) chk("in_ready_in_store", ir, 0);
            if (ov && out_ready) begin
                cap_q.push_back(od);
                if (exp_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL extra_beat: got data %0d, expected no beat", od);
                end else begin
                    chk("out_data", od, exp_q.pop_front());
                    chk("out_last", ol, expl_q.pop_front());
                end
            end
            prev_stall = ov && !out_ready;
            prev_od    = od;
            prev_ol    = ol;
        end
    end

    task automatic pulse_start(input int s);
        if (s != 0) start1 = 1'b1; else start0 = 1'b1;
    endtask

    task automatic load_op(input int s, input bit acc, input int a[16], input int b[16],
                           input bit gaps, input bit poke);
        int     n = (s != 0) ? 4 : 2;
        longint mask = (s != 0) ? 64'hFFFF : 64'hFFFF_FFFF;
        longint sum;
        int     guard;
        sel = s;
        cap_q.delete();
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                sum = acc ? mc[s][i*n+j] : 0;
                for (int k = 0; k < n; k++)
                    sum += longint'(a[i*n+k]) * longint'(b[k*n+j]);
                mc[s][i*n+j] = sum & mask;
                exp_q.push_back(mc[s][i*n+j]);
                expl_q.push_back(i == n-1 && j == n-1);
            end
        acc_en = acc;
        pulse_start(s);
        start_cyc = cyc;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        acc_en = ~acc;
        chk("busy_after_start", bz, 1);
        chk("in_ready_after_start", ir, 1);
        for (int idx = 0; idx < n*n; idx++) begin
            if (poke && idx == 2) begin
                in_valid = 1'b0;
                pulse_start(s);
                @(posedge clk); #1;
                start0 = 1'b0; start1 = 1'b0;
            end
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_a = 16'(a[idx]);
            in_b = 16'(b[idx]);
            guard = 0;
            while (!ir && guard < 50) begin @(posedge clk); #1; guard++; end
            if (!ir) begin
                nvec++; nerr++;
                $display("FAIL load_timeout: in_ready stayed 0, expected 1");
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input int n, input bit bp, input bit poke, input bit lat);
        int base = done_cnt;
        int guard = 0;
        bit poked = 1'b0;
        while (done_cnt == base && guard < 500) begin
            if (bp) out_ready = 1'($urandom_range(0, 1));
            if (poke && !poked && ov) begin pulse_start(sel); poked = 1'b1; end
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            guard++;
        end
        out_ready = 1'b1;
        if (done_cnt == base) begin
            nvec++; nerr++;
            $display("FAIL done_timeout: no done after %0d cycles, expected one", guard);
        end
        if (lat) chk("latency", done_cyc - start_cyc, tc_latency(n));
        repeat (4) @(posedge clk);
        #1;
        chk("single_done", done_cnt - base, 1);
        chk("beats_outstanding", exp_q.size(), 0);
        chk("busy_idle", bz, 0);
    endtask

    task automatic chk_lits(input string nm, input longint lit[16], input int cnt);
        chk({nm, "_count"}, cap_q.size(), cnt);
        for (int i = 0; i < cnt && i < cap_q.size(); i++) chk(nm, cap_q[i], lit[i]);
    endtask

    int     A1[16], B1[16], AM[16], AI[16], BI[16];
    longint L19[16], L38[16], LZ[16], LNB[16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        A1  = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        B1  = '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        L19 = '{19, 22, 43, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        L38 = '{38, 44, 86, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            AM[i]  = -128;
            AI[i]  = (i % 5 == 0) ? -1 : 0;
            BI[i]  = i + 1;
            LZ[i]  = 0;
            LNB[i] = 65536 - (i + 1);
        end
        for (int s = 0; s < 2; s++) for (int i = 0; i < 16; i++) mc[s][i] = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", ir0, 0);
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_data", od0, 0);
        chk("rst_out_last", ol0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_done", dn0, 0);
        chk("rst_busy_n4", bz1, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // plain multiply, then accumulate on top
        load_op(0, 1'b0, A1, B1, 1'b0, 1'b0);
        finish_op(2, 1'b0, 1'b0, 1'b1);
        chk("latency_n2_literal", done_cyc - start_cyc, 17);
        chk_lits("n2_mul", L19, 4);
        load_op(0, 1'b1, A1, B1, 1'b0, 1'b0);
        finish_op(2, 1'b0, 1'b0, 1'b1);
        chk_lits("n2_acc", L38, 4);

        // input gaps, output backpressure, stray starts in LOAD and STORE
        load_op(0, 1'b0, A1, B1, 1'b1, 1'b1);
        finish_op(2, 1'b1, 1'b1, 1'b0);
        chk_lits("n2_bp", L19, 4);

        // reset in the 3rd EXEC cycle wipes C; accumulate then starts from zero
        load_op(0, 1'b0, A1, B1, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("rst_mid_busy", bz0, 0);
        chk("rst_mid_in_ready", ir0, 0);
        chk("rst_mid_out_valid", ov0, 0);
        chk("rst_mid_done", dn0, 0);
        exp_q.delete();
        expl_q.delete();
        for (int s = 0; s < 2; s++) for (int i = 0; i < 16; i++) mc[s][i] = 0;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid_no_beats", cap_q.size(), 0);
        load_op(0, 1'b1, A1, B1, 1'b0, 1'b0);
        finish_op(2, 1'b0, 1'b0, 1'b1);
        chk_lits("n2_after_rst", L19, 4);

        // N=4, DW=8, AW=16: wrap to zero, then negated identity
        load_op(1, 1'b0, AM, AM, 1'b0, 1'b0);
        finish_op(4, 1'b0, 1'b0, 1'b1);
        chk_lits("n4_wrap", LZ, 16);
        load_op(1, 1'b0, AI, BI, 1'b0, 1'b0);
        finish_op(4, 1'b0, 1'b0, 1'b1);
        chk_lits("n4_negid", LNB, 16);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
